// File: rtl/ysyx_24080006_pkg.sv
// Shared types for the IFU/LSU to data-SRAM AXI-lite arbiter:
// channel structs, FSM state encodings and master index constants.
package ysyx_24080006_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    // Master indices as stored in the grant and last-grant registers.
    localparam logic ARB_M0 = 1'b0;  // IFU
    localparam logic ARB_M1 = 1'b1;  // LSU

    typedef enum logic [1:0] {
        R_IDLE,
        R_AR,
        R_R
    } arb_r_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_AW,
        W_B
    } arb_w_state_e;

    // Read channel, master to slave: AR request plus R-channel ready.
    typedef struct packed {
        logic                  arvalid;
        logic [AXI_ADDR_W-1:0] araddr;
        logic                  rready;
    } axi_r_m2s_t;

    // Read channel, slave to master: AR ready plus R-channel payload.
    typedef struct packed {
        logic                  arready;
        logic                  rvalid;
        logic [AXI_DATA_W-1:0] rdata;
        logic [1:0]            rresp;
        logic                  rlast;
    } axi_r_s2m_t;

    // Write channel, master to slave: AW and W travel together, plus B ready.
    typedef struct packed {
        logic                  awvalid;
        logic [AXI_ADDR_W-1:0] awaddr;
        logic                  wvalid;
        logic [AXI_DATA_W-1:0] wdata;
        logic [AXI_STRB_W-1:0] wstrb;
        logic                  bready;
    } axi_w_m2s_t;

    // Write channel, slave to master: AW/W readies plus B response.
    typedef struct packed {
        logic       awready;
        logic       wready;
        logic       bvalid;
        logic [1:0] bresp;
    } axi_w_s2m_t;

endpackage

// File: rtl/axi_arb_pick.sv
// Two-way grant picker shared by the read and write channels.
// Build option YSYX_24080006_ARB_RR_EN: ties go to the master that did not
// win last time; otherwise ties go to FIXED_PRIO.
module axi_arb_pick
    import ysyx_24080006_pkg::*;
#(
    parameter logic FIXED_PRIO = ARB_M1
) (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt
);

`ifdef YSYX_24080006_ARB_RR_EN
    logic tie_winner;
    logic unused_prio;

    assign tie_winner  = ~last;
    assign unused_prio = FIXED_PRIO;
`else
    logic tie_winner;
    logic unused_last;

    assign tie_winner  = FIXED_PRIO;
    assign unused_last = last;
`endif

    // Lone requester always wins; a tie is resolved by the configured policy.
    always_comb begin
        // NOTE: a default assignment on entry keeps every path covered so no latch is inferred.
        gnt = ARB_M0;
        if (req[0] && req[1]) begin
            gnt = tie_winner;
        end else if (req[1]) begin
            gnt = ARB_M1;
        end
    end

endmodule

// File: rtl/axi_arbiter_2to1.sv
// 2:1 AXI-lite arbiter in front of the data SRAM (m0 = IFU, m1 = LSU).
// Read and write channels have independent FSMs and grants; a grant covers
// the address handshake and the response handshake. Outputs are decoded from
// registered state, so IDLE presents all-zero channels in both directions.
// Build option YSYX_24080006_ARB_RR_EN: per-channel round-robin on ties.
module axi_arbiter_2to1
    import ysyx_24080006_pkg::*;
#(
    parameter logic FIXED_PRIO = ARB_M1
) (
    input  logic       clock,
    input  logic       reset,
    input  axi_w_m2s_t m0_w_m2s,
    output axi_w_s2m_t m0_w_s2m,
    input  axi_r_m2s_t m0_r_m2s,
    output axi_r_s2m_t m0_r_s2m,
    input  axi_w_m2s_t m1_w_m2s,
    output axi_w_s2m_t m1_w_s2m,
    input  axi_r_m2s_t m1_r_m2s,
    output axi_r_s2m_t m1_r_s2m,
    output axi_w_m2s_t s_w_m2s,
    input  axi_w_s2m_t s_w_s2m,
    output axi_r_m2s_t s_r_m2s,
    input  axi_r_s2m_t s_r_s2m
);

    arb_r_state_e r_state;
    arb_w_state_e w_state;
    logic         r_gnt;
    logic         w_gnt;
    logic         r_last;
    logic         w_last;
    logic [1:0]   r_req;
    logic [1:0]   w_req;
    logic         r_pick;
    logic         w_pick;
    axi_r_m2s_t   r_sel;
    axi_r_s2m_t   r_rsp;
    axi_w_m2s_t   w_sel;
    axi_w_s2m_t   w_rsp;

    // The SRAM takes AW and W in the same cycle, so a write request needs both.
    assign r_req = {m1_r_m2s.arvalid, m0_r_m2s.arvalid};
    assign w_req = {m1_w_m2s.awvalid & m1_w_m2s.wvalid,
                    m0_w_m2s.awvalid & m0_w_m2s.wvalid};

`ifndef YSYX_24080006_ARB_RR_EN
    // Fixed priority: the picker ignores history, so no last-grant state exists.
    assign r_last = ARB_M1;
    assign w_last = ARB_M1;
`endif

    axi_arb_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick_r (
        .req  (r_req),
        .last (r_last),
        .gnt  (r_pick)
    );

    axi_arb_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick_w (
        .req  (w_req),
        .last (w_last),
        .gnt  (w_pick)
    );

    // Read FSM: arbitrate in IDLE, hold the grant through AR and the R beat.
    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            r_state <= R_IDLE;
            r_gnt   <= ARB_M0;
`ifdef YSYX_24080006_ARB_RR_EN
            r_last  <= ARB_M1;
`endif
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (|r_req) begin
                        r_gnt   <= r_pick;
                        r_state <= R_AR;
`ifdef YSYX_24080006_ARB_RR_EN
                        r_last  <= r_pick;
`endif
                    end
                end
                R_AR: begin
                    if (s_r_m2s.arvalid && s_r_s2m.arready) begin
                        r_state <= R_R;
                    end
                end
                R_R: begin
                    if (s_r_s2m.rvalid && s_r_m2s.rready && s_r_s2m.rlast) begin
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Write FSM: arbitrate in IDLE, hold the grant through AW+W and the B beat.
    always_ff @(posedge clock) begin
        if (reset) begin
            w_state <= W_IDLE;
            w_gnt   <= ARB_M0;
`ifdef YSYX_24080006_ARB_RR_EN
            w_last  <= ARB_M1;
`endif
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (|w_req) begin
                        w_gnt   <= w_pick;
                        w_state <= W_AW;
`ifdef YSYX_24080006_ARB_RR_EN
                        w_last  <= w_pick;
`endif
                    end
                end
                W_AW: begin
                    if (s_w_m2s.awvalid && s_w_s2m.awready &&
                        s_w_m2s.wvalid  && s_w_s2m.wready) begin
                        w_state <= W_B;
                    end
                end
                W_B: begin
                    if (s_w_s2m.bvalid && s_w_m2s.bready) begin
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read routing: arvalid reaches the SRAM only in R_AR because it samples
    // arvalid as a level; the loser and every IDLE cycle see zeros.
    always_comb begin
        s_r_m2s  = '0;
        r_rsp    = '0;
        m0_r_s2m = '0;
        m1_r_s2m = '0;
        r_sel    = (r_gnt == ARB_M1) ? m1_r_m2s : m0_r_m2s;
        case (r_state)
            R_AR: begin
                s_r_m2s.arvalid = r_sel.arvalid;
                s_r_m2s.araddr  = r_sel.araddr;
                s_r_m2s.rready  = r_sel.rready;
                r_rsp.arready   = s_r_s2m.arready;
            end
            R_R: begin
                s_r_m2s.rready  = r_sel.rready;
                r_rsp.rvalid    = s_r_s2m.rvalid;
                r_rsp.rdata     = s_r_s2m.rdata;
                r_rsp.rresp     = s_r_s2m.rresp;
                r_rsp.rlast     = s_r_s2m.rlast;
            end
            default: ;
        endcase
        if (r_gnt == ARB_M1) begin
            m1_r_s2m = r_rsp;
        end else begin
            m0_r_s2m = r_rsp;
        end
    end

    // Write routing: AW/W reach the SRAM only in W_AW; B is forwarded in W_B.
    always_comb begin
        s_w_m2s  = '0;
        w_rsp    = '0;
        m0_w_s2m = '0;
        m1_w_s2m = '0;
        w_sel    = (w_gnt == ARB_M1) ? m1_w_m2s : m0_w_m2s;
        case (w_state)
            W_AW: begin
                s_w_m2s.awvalid = w_sel.awvalid;
                s_w_m2s.awaddr  = w_sel.awaddr;
                s_w_m2s.wvalid  = w_sel.wvalid;
                s_w_m2s.wdata   = w_sel.wdata;
                s_w_m2s.wstrb   = w_sel.wstrb;
                s_w_m2s.bready  = w_sel.bready;
                w_rsp.awready   = s_w_s2m.awready;
                w_rsp.wready    = s_w_s2m.wready;
            end
            W_B: begin
                s_w_m2s.bready  = w_sel.bready;
                w_rsp.bvalid    = s_w_s2m.bvalid;
                w_rsp.bresp     = s_w_s2m.bresp;
            end
            default: ;
        endcase
        if (w_gnt == ARB_M1) begin
            m1_w_s2m = w_rsp;
        end else begin
            m0_w_s2m = w_rsp;
        end
    end

endmodule

// File: tb/tb_axi_arbiter_2to1.sv
// Directed bench for axi_arbiter_2to1 with a small behavioural SRAM slave.
// Tie expectations follow YSYX_24080006_ARB_RR_EN and the default FIXED_PRIO.
module tb_axi_arbiter_2to1;
    import ysyx_24080006_pkg::*;

    localparam logic [31:0] A0 = 32'h8000_0000;
    localparam logic [31:0] A1 = 32'h8000_0004;
    localparam logic [31:0] A_W = 32'h8000_0010;
    localparam logic [31:0] A_P = 32'h8000_0014;
    localparam logic [31:0] A_R = 32'h8000_0020;
`ifdef YSYX_24080006_ARB_RR_EN
    localparam logic TIE_FIRST = 1'b0;
`else
    localparam logic TIE_FIRST = 1'b1;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    axi_w_m2s_t m0_w_m2s, m1_w_m2s, s_w_m2s;
    axi_w_s2m_t m0_w_s2m, m1_w_s2m, s_w_s2m;
    axi_r_m2s_t m0_r_m2s, m1_r_m2s, s_r_m2s;
    axi_r_s2m_t m0_r_s2m, m1_r_s2m, s_r_s2m;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:63];
    logic        sram_rvalid = 1'b0;
    logic [31:0] sram_rdata  = 32'h0;
    logic        sram_bvalid = 1'b0;

    always #5 clock = ~clock;

    axi_arbiter_2to1 dut (
        .clock    (clock),
        .reset    (reset),
        .m0_w_m2s (m0_w_m2s),
        .m0_w_s2m (m0_w_s2m),
        .m0_r_m2s (m0_r_m2s),
        .m0_r_s2m (m0_r_s2m),
        .m1_w_m2s (m1_w_m2s),
        .m1_w_s2m (m1_w_s2m),
        .m1_r_m2s (m1_r_m2s),
        .m1_r_s2m (m1_r_s2m),
        .s_w_m2s  (s_w_m2s),
        .s_w_s2m  (s_w_s2m),
        .s_r_m2s  (s_r_m2s),
        .s_r_s2m  (s_r_s2m)
    );

    // SRAM model: always ready; response one cycle after the address beat.
    // Its response state is deliberately not reset, so a reset arbiter must hide it.
    always_comb begin
        s_r_s2m         = '0;
        s_r_s2m.arready = 1'b1;
        s_r_s2m.rvalid  = sram_rvalid;
        s_r_s2m.rdata   = sram_rdata;
        s_r_s2m.rlast   = sram_rvalid;
        s_w_s2m         = '0;
        s_w_s2m.awready = 1'b1;
        s_w_s2m.wready  = 1'b1;
        s_w_s2m.bvalid  = sram_bvalid;
    end

    always @(posedge clock) begin
        if (s_r_m2s.arvalid && s_r_s2m.arready) begin
            sram_rvalid <= 1'b1;
            sram_rdata  <= mem[s_r_m2s.araddr[7:2]];
        end else if (sram_rvalid && s_r_m2s.rready) begin
            sram_rvalid <= 1'b0;
        end
        if (s_w_m2s.awvalid && s_w_m2s.wvalid) begin
            for (int b = 0; b < 4; b++) begin
                if (s_w_m2s.wstrb[b]) begin
                    mem[s_w_m2s.awaddr[7:2]][8*b +: 8] <= s_w_m2s.wdata[8*b +: 8];
                end
            end
            sram_bvalid <= 1'b1;
        end else if (sram_bvalid && s_w_m2s.bready) begin
            sram_bvalid <= 1'b0;
        end
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic axi_r_s2m_t rsp(input logic idx);
        return idx ? m1_r_s2m : m0_r_s2m;
    endfunction

    task automatic set_ar(input logic idx, input logic v, input logic [31:0] addr);
        if (idx) begin
            m1_r_m2s.arvalid = v;
            m1_r_m2s.araddr  = v ? addr : 32'h0;
            m1_r_m2s.rready  = 1'b1;
        end else begin
            m0_r_m2s.arvalid = v;
            m0_r_m2s.araddr  = v ? addr : 32'h0;
            m0_r_m2s.rready  = 1'b1;
        end
    endtask

    task automatic clear_inputs();
        m0_w_m2s = '0;
        m1_w_m2s = '0;
        m0_r_m2s = '0;
        m1_r_m2s = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    // Uncontended read by master idx: bubble, AR, then the data beat.
    task automatic rd(input logic idx, input logic [31:0] addr, input logic [31:0] exp,
                      input string tag);
        set_ar(idx, 1'b1, addr);
        settle();
        check1({tag, "_bubble_rvalid"}, rsp(idx).rvalid, 1'b0);
        check1({tag, "_bubble_s_arvalid"}, s_r_m2s.arvalid, 1'b0);
        cyc();
        check1({tag, "_ar_arready"}, rsp(idx).arready, 1'b1);
        check1({tag, "_ar_other_arready"}, rsp(~idx).arready, 1'b0);
        check32({tag, "_ar_s_araddr"}, s_r_m2s.araddr, addr);
        cyc();
        set_ar(idx, 1'b0, addr);
        settle();
        check1({tag, "_r_rvalid"}, rsp(idx).rvalid, 1'b1);
        check32({tag, "_r_rdata"}, rsp(idx).rdata, exp);
        check1({tag, "_r_rlast"}, rsp(idx).rlast, 1'b1);
        check1({tag, "_r_other_rvalid"}, rsp(~idx).rvalid, 1'b0);
        check1({tag, "_r_s_arvalid"}, s_r_m2s.arvalid, 1'b0);
        cyc();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        mem[0] <= 32'hDEAD_BEEF;
        mem[1] <= 32'hCAFE_F00D;
        mem[8] <= 32'h0BAD_F00D;
        clear_inputs();

        // Reset holds everything idle even with requests present.
        m0_r_m2s.arvalid = 1'b1;
        m0_r_m2s.araddr  = A0;
        m1_w_m2s.awvalid = 1'b1;
        m1_w_m2s.wvalid  = 1'b1;
        cyc();
        cyc();
        settle();
        check1("rst_s_r_zero", |s_r_m2s, 1'b0);
        check1("rst_s_w_zero", |s_w_m2s, 1'b0);
        check1("rst_m0_r_zero", |m0_r_s2m, 1'b0);
        check1("rst_m1_w_zero", |m1_w_s2m, 1'b0);
        clear_inputs();
        reset = 1'b0;

        // T1: lone m0 read, response in the third cycle.
        rd(1'b0, A0, 32'hDEAD_BEEF, "t1");
        settle();
        check1("t1_done_rvalid", m0_r_s2m.rvalid, 1'b0);

        // T2: simultaneous reads from a fresh reset.
        do_reset();
        set_ar(1'b0, 1'b1, A0);
        set_ar(1'b1, 1'b1, A1);
        settle();
        check1("t2_bubble_s_arvalid", s_r_m2s.arvalid, 1'b0);
        cyc();
        check32("t2_first_araddr", s_r_m2s.araddr, TIE_FIRST ? A1 : A0);
        check1("t2_first_arready", rsp(TIE_FIRST).arready, 1'b1);
        check1("t2_second_arready", rsp(~TIE_FIRST).arready, 1'b0);
        cyc();
        set_ar(TIE_FIRST, 1'b0, 32'h0);
        settle();
        check1("t2_first_rvalid", rsp(TIE_FIRST).rvalid, 1'b1);
        check32("t2_first_rdata", rsp(TIE_FIRST).rdata,
                TIE_FIRST ? 32'hCAFE_F00D : 32'hDEAD_BEEF);
        check1("t2_second_rvalid", rsp(~TIE_FIRST).rvalid, 1'b0);
        cyc();
        settle();
        check1("t2_idle_s_arvalid", s_r_m2s.arvalid, 1'b0);
        check1("t2_idle_second_arready", rsp(~TIE_FIRST).arready, 1'b0);
        cyc();
        check32("t2_second_araddr", s_r_m2s.araddr, TIE_FIRST ? A0 : A1);
        check1("t2_second_ar_arready", rsp(~TIE_FIRST).arready, 1'b1);
        cyc();
        set_ar(~TIE_FIRST, 1'b0, 32'h0);
        settle();
        check1("t2_second_r_rvalid", rsp(~TIE_FIRST).rvalid, 1'b1);
        check32("t2_second_rdata", rsp(~TIE_FIRST).rdata,
                TIE_FIRST ? 32'hDEAD_BEEF : 32'hCAFE_F00D);
        cyc();

        // T3: m1 write and m0 read proceed concurrently.
        m1_w_m2s.awvalid = 1'b1;
        m1_w_m2s.awaddr  = A_W;
        m1_w_m2s.wvalid  = 1'b1;
        m1_w_m2s.wdata   = 32'h1234_5678;
        m1_w_m2s.wstrb   = 4'hF;
        m1_w_m2s.bready  = 1'b1;
        set_ar(1'b0, 1'b1, A_R);
        settle();
        check1("t3_bubble_s_awvalid", s_w_m2s.awvalid, 1'b0);
        cyc();
        check1("t3_s_awvalid", s_w_m2s.awvalid, 1'b1);
        check32("t3_s_awaddr", s_w_m2s.awaddr, A_W);
        check32("t3_s_wdata", s_w_m2s.wdata, 32'h1234_5678);
        check1("t3_m1_awready", m1_w_s2m.awready, 1'b1);
        check1("t3_m0_awready", m0_w_s2m.awready, 1'b0);
        check32("t3_s_araddr", s_r_m2s.araddr, A_R);
        cyc();
        m1_w_m2s = '0;
        m1_w_m2s.bready = 1'b1;
        set_ar(1'b0, 1'b0, 32'h0);
        settle();
        check1("t3_m1_bvalid", m1_w_s2m.bvalid, 1'b1);
        check1("t3_m0_bvalid", m0_w_s2m.bvalid, 1'b0);
        check1("t3_s_awvalid_wb", s_w_m2s.awvalid, 1'b0);
        check1("t3_m0_rvalid", m0_r_s2m.rvalid, 1'b1);
        check32("t3_m0_rdata", m0_r_s2m.rdata, 32'h0BAD_F00D);
        cyc();
        settle();
        check1("t3_done_bvalid", m1_w_s2m.bvalid, 1'b0);
        rd(1'b0, A_W, 32'h1234_5678, "t3_rb");

        // T4: AW without W is never granted.
        m1_w_m2s.awvalid = 1'b1;
        m1_w_m2s.awaddr  = A_P;
        m1_w_m2s.wdata   = 32'hA5A5_A5A5;
        m1_w_m2s.wstrb   = 4'b0011;
        m1_w_m2s.bready  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            check1("t4_no_grant_s_awvalid", s_w_m2s.awvalid, 1'b0);
            check1("t4_no_grant_awready", m1_w_s2m.awready, 1'b0);
            cyc();
        end
        m1_w_m2s.wvalid = 1'b1;
        settle();
        check1("t4_eval_s_awvalid", s_w_m2s.awvalid, 1'b0);
        cyc();
        check1("t4_grant_s_awvalid", s_w_m2s.awvalid, 1'b1);
        check32("t4_grant_wstrb", 32'(s_w_m2s.wstrb), 32'h3);
        cyc();
        m1_w_m2s = '0;
        m1_w_m2s.bready = 1'b1;
        settle();
        check1("t4_bvalid", m1_w_s2m.bvalid, 1'b1);
        cyc();
        rd(1'b1, A_P, 32'h0000_A5A5, "t4_rb");

        // T5: m0 stalls its R beat while m1 waits.
        m0_r_m2s.arvalid = 1'b1;
        m0_r_m2s.araddr  = A0;
        m0_r_m2s.rready  = 1'b0;
        cyc();
        set_ar(1'b1, 1'b1, A1);
        cyc();
        m0_r_m2s.arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check1("t5_stall_s_arvalid", s_r_m2s.arvalid, 1'b0);
            check1("t5_stall_m0_rvalid", m0_r_s2m.rvalid, 1'b1);
            check32("t5_stall_m0_rdata", m0_r_s2m.rdata, 32'hDEAD_BEEF);
            check1("t5_stall_m1_arready", m1_r_s2m.arready, 1'b0);
            cyc();
        end
        m0_r_m2s.rready = 1'b1;
        cyc();
        settle();
        check1("t5_idle_m0_rvalid", m0_r_s2m.rvalid, 1'b0);
        check1("t5_idle_m1_arready", m1_r_s2m.arready, 1'b0);
        cyc();
        check1("t5_m1_arready", m1_r_s2m.arready, 1'b1);
        check32("t5_m1_araddr", s_r_m2s.araddr, A1);
        cyc();
        set_ar(1'b1, 1'b0, 32'h0);
        settle();
        check1("t5_m1_rvalid", m1_r_s2m.rvalid, 1'b1);
        check32("t5_m1_rdata", m1_r_s2m.rdata, 32'hCAFE_F00D);
        cyc();

        // T6: reset during R_R hides the in-flight response.
        m0_r_m2s.arvalid = 1'b1;
        m0_r_m2s.araddr  = A_R;
        m0_r_m2s.rready  = 1'b0;
        cyc();
        cyc();
        m0_r_m2s.arvalid = 1'b0;
        settle();
        check1("t6_pre_m0_rvalid", m0_r_s2m.rvalid, 1'b1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        settle();
        check1("t6_rst_m0_rvalid", m0_r_s2m.rvalid, 1'b0);
        check1("t6_rst_m1_rvalid", m1_r_s2m.rvalid, 1'b0);
        check1("t6_rst_s_arvalid", s_r_m2s.arvalid, 1'b0);
        check1("t6_rst_s_awvalid", s_w_m2s.awvalid, 1'b0);
        clear_inputs();
        rd(1'b1, A1, 32'hCAFE_F00D, "t6_m1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_arbiter_2to1.md
Name: axi_arbiter_2to1

Overview:
- Two-master to one-slave AXI-lite arbiter placed directly upstream of the data SRAM slave.
- Master 0 is the IFU (instruction fetch); master 1 is the LSU (load/store unit). The slave side connects to the SRAM's read and write channel structs.
- Read and write channels are arbitrated independently. Each grant lasts one full transaction: the address handshake followed by the response handshake.

Parameters:
- FIXED_PRIO, default 1: master index that wins a simultaneous request when round-robin is compiled out.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_w_m2s  in  axi_w_m2s_t  IFU write request
- m0_w_s2m  out  axi_w_s2m_t  IFU write response
- m0_r_m2s  in  axi_r_m2s_t  IFU read request
- m0_r_s2m  out  axi_r_s2m_t  IFU read response
- m1_w_m2s  in  axi_w_m2s_t  LSU write request
- m1_w_s2m  out  axi_w_s2m_t  LSU write response
- m1_r_m2s  in  axi_r_m2s_t  LSU read request
- m1_r_s2m  out  axi_r_s2m_t  LSU read response
- s_w_m2s  out  axi_w_m2s_t  write request to SRAM
- s_w_s2m  in  axi_w_s2m_t  write response from SRAM
- s_r_m2s  out  axi_r_m2s_t  read request to SRAM
- s_r_s2m  in  axi_r_s2m_t  read response from SRAM

Behaviour:
- Clock is clock; reset is synchronous and active-high. Both FSMs reset to IDLE and all done/last-grant flags clear.
- Outputs are combinational functions of registered state. In IDLE:
  - every valid/ready toward masters is 0;
  - every valid/ready toward the slave is 0;
  - data and address fields are driven 0.
- Read FSM states: R_IDLE, R_AR, R_R. A grant register g selects m0 or m1.
  - R_IDLE: if any arvalid is high, pick a winner into g and go to R_AR next cycle. This is a 1-cycle arbitration bubble.
  - R_AR: s_r_m2s.arvalid/araddr/rready come from m_g. m_g sees arready = s.arready. On arvalid && arready, go to R_R.
  - R_R: s_r_m2s.arvalid is forced 0, because the SRAM samples arvalid level-sensitively. rready is forwarded from m_g. m_g sees rvalid/rdata/rlast from the slave. On rvalid && rready && rlast, return to R_IDLE.
  - The non-granted master sees arready = 0 and rvalid = 0 throughout. Its request stays pending.
- Write FSM states: W_IDLE, W_AW, W_B. It has its own grant register.
  - W_IDLE: a request is awvalid && wvalid of the same master. Pick a winner and go to W_AW next cycle.
  - W_AW: forward awvalid/awaddr/wvalid/wdata/wstrb/bready from the granted master. Go to W_B on a combined awvalid && awready && wvalid && wready in one cycle. The SRAM requires AW and W together; a master presenting only one is not granted.
  - W_B: aw/w valids to the slave are forced 0. bvalid is forwarded. On bvalid && bready, return to W_IDLE.
- Minimum latency: read response 3 cycles after arvalid is first seen by an idle arbiter; write response likewise.
- Read and write FSMs may be busy at the same time, for the same or different masters.
- Simultaneous request: with round-robin the master not granted last wins. Otherwise the winner is FIXED_PRIO.
- Back-to-back: returning to IDLE costs one cycle. The next grant is evaluated in that IDLE cycle.
- Reset mid-transaction: the FSM returns to IDLE. An in-flight slave response is not forwarded to any master.

Optional Feature:
- YSYX_24080006_ARB_RR_EN defined: a one-bit last-grant register per channel, updated on each grant. On a tie, the master that did not win last wins. Reset value of last-grant is m1, so m0 wins the first tie.
- Undefined: fixed priority per FIXED_PRIO; no last-grant register.

Decomposition:
- Package ysyx_24080006_pkg: arb_r_state_e (R_IDLE/R_AR/R_R), arb_w_state_e (W_IDLE/W_AW/W_B), localparams ARB_M0 = 1'b0 and ARB_M1 = 1'b1. The existing axi_* structs are reused.
- Sub-module axi_arb_pick: a 2-way grant picker with inputs req[1:0] and last, and output gnt. It holds the round-robin/fixed-priority logic and is instantiated once per channel.

Test Plan:
- m0 reads 0x8000_0000 alone, SRAM holds 0xDEADBEEF there → m0 sees rvalid with rdata 0xDEADBEEF and rlast = 1. m1_r_s2m.rvalid stays 0. Total 3 cycles.
- m0 and m1 assert arvalid in the same cycle (0x8000_0000 and 0x8000_0004):
  - with RR_EN: m0 is served first, then m1 after 1 idle cycle;
  - without RR_EN and FIXED_PRIO = 1: m1 is served first.
- m1 writes 0x12345678 with wstrb 0xF to 0x8000_0010 while m0 reads 0x8000_0020 → both complete concurrently. A subsequent m0 read of 0x8000_0010 returns 0x12345678.
- m1 asserts awvalid without wvalid for 5 cycles → no grant and s_w_m2s.awvalid stays 0. Raising wvalid grants next cycle.
- m0 holds rready = 0 for 4 cycles in R_R → s_r_m2s.arvalid stays 0, rdata stays stable, and m1's pending read waits.
- reset asserted in R_R → next cycle all valids are 0 and the FSM is in R_IDLE. A fresh m1 read then completes normally.
